fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of the main decoder.
- Owns the PC and issues word reads to instruction memory over a variable-latency req/ack handshake.
- Holds the fetched word in an IF/ID register and presents its opcode field to the decoder, with a valid/ready handshake toward decode.
- Accepts redirects (taken BEQ/BNE, J, JAL targets) from downstream and discards any fetch they supersede.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 23 ++
 rtl/ifid_reg.sv | 40 ++++
 rtl/fetch_stage.sv | 76 +++++++
 tb/tb_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode field values, the NOP word and the fetch FSM encoding.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {FETCH, WAIT_ID} fetch_state_t;

  function automatic logic [5:0] opcode(input logic [31:0] w);
    return w[31:26];
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory req/ack, redirect input and the IF/ID handshake to decode.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc_plus4;

  modport master (
    output imem_req, imem_addr, id_valid, instr, op, pc_plus4,
    input  imem_ack, imem_rdata, redirect, redirect_target, id_ready
  );
  modport slave (
    input  imem_req, imem_addr, id_valid, instr, op, pc_plus4,
    output imem_ack, imem_rdata, redirect, redirect_target, id_ready
  );
endinterface

// File: rtl/ifid_reg.sv
// Single-entry valid/ready pipeline register carrying an instruction and its PC+4, with flush.
module ifid_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4
);
  logic [31:0] instr_q;

  // Accept when empty, or when the held word drains in the same cycle.
  assign in_ready  = !out_valid || out_ready;
  assign out_instr = out_valid ? instr_q : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      instr_q   <= NOP_INSTR;
      out_pc4   <= 32'h0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      instr_q   <= in_instr;
      out_pc4   <= in_pc4;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues word reads over req/ack, fills IF/ID, honours redirects.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  fetch_stage_if.master   bus
);
  fetch_state_t state;
  logic [31:0]  pc;
  logic         req;
  logic         kill;
  logic         fire;
  logic         ld_rdy;

  assign fire          = req && bus.imem_ack;
  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.op        = opcode(bus.instr);

  ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect),
    .in_valid  (fire && !kill),
    .in_instr  (bus.imem_rdata),
    .in_pc4    (pc + 32'd4),
    .in_ready  (ld_rdy),
    .out_ready (bus.id_ready),
    .out_valid (bus.id_valid),
    .out_instr (bus.instr),
    .out_pc4   (bus.pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      req   <= 1'b0;
      kill  <= 1'b0;
    end else if (bus.redirect) begin
      pc    <= {bus.redirect_target[31:2], 2'b00};
      state <= FETCH;
      req   <= 1'b1;
      // An ack this cycle retires the old request; otherwise its ack is still owed and must be dropped.
      if (fire)     kill <= 1'b0;
      else if (req) kill <= 1'b1;
    end else begin
      case (state)
        FETCH: begin
          req <= 1'b1;
          if (fire) begin
            if (kill) begin
              kill <= 1'b0;
            end else if (ld_rdy) begin
              pc <= pc + 32'd4;
            end else begin
              // IF/ID is blocked: drop the word without advancing PC, it is refetched later.
              state <= WAIT_ID;
              req   <= 1'b0;
            end
          end
        end
        WAIT_ID: begin
          if (ld_rdy) begin
            state <= FETCH;
            req   <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed latency/stall/redirect/reset scenarios plus a randomized
// run checked against a program-order model of what decode should receive.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  fetch_stage_if bus();

  int checks = 0;
  int errors = 0;

  // Memory responder state
  int          lat_fixed = 0;
  int          m_cnt = 0;
  int          m_lat = 0;
  logic        m_open = 1'b0;
  logic [31:0] m_a = 32'h0;
  logic        ack_force = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C08_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Data belongs to the address captured when the request opened, so stale data stays distinguishable.
  assign bus.imem_ack   = ack_force || (bus.imem_req && (m_cnt == m_lat));
  assign bus.imem_rdata = m_open ? memw(m_a) : memw(bus.imem_addr);

  always @(posedge clk) begin
    if (!reset || !bus.imem_req || bus.imem_ack) begin
      m_cnt  <= 0;
      m_open <= 1'b0;
      m_lat  <= (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    end else begin
      m_cnt  <= m_cnt + 1;
      m_open <= 1'b1;
      if (!m_open) m_a <= bus.imem_addr;
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    lat_fixed = 0; bus.id_ready = 1'b1;
    do_reset();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.id_valid); end
    checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
    checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", bus.pc_plus4); end
    checks++; if (bus.op !== 6'h0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_op_addr: got %h/%h want 0/0", bus.op, bus.imem_addr); end
  endtask

  task automatic test_zero_wait();
    lat_fixed = 0; bus.id_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * (c - 1))) begin
        errors++; $display("FAIL zw_addr c%0d: got req=%b addr=%h want 1/%h", c, bus.imem_req, bus.imem_addr, 4 * (c - 1));
      end
      checks++;
      if (bus.id_valid !== (c >= 2)) begin errors++; $display("FAIL zw_valid c%0d: got %b want %b", c, bus.id_valid, c >= 2); end
      if (c == 2) begin
        checks++;
        if (bus.op !== 6'b100011 || bus.pc_plus4 !== 32'h4 || bus.instr !== 32'h8C08_0004) begin
          errors++; $display("FAIL zw_word: got op=%b pc4=%h instr=%h want 100011/4/8c080004", bus.op, bus.pc_plus4, bus.instr);
        end
      end
    end
  endtask

  task automatic test_latency();
    lat_fixed = 2; bus.id_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.id_valid !== 1'b0) begin
          errors++; $display("FAIL lat_wait c%0d: got req=%b addr=%h valid=%b want 1/0/0", c, bus.imem_req, bus.imem_addr, bus.id_valid);
        end
      end else begin
        checks++;
        if (bus.id_valid !== 1'b1 || bus.pc_plus4 !== 32'h4 || bus.instr !== memw(32'h0)) begin
          errors++; $display("FAIL lat_done: got valid=%b pc4=%h instr=%h want 1/4/%h", bus.id_valid, bus.pc_plus4, bus.instr, memw(32'h0));
        end
      end
    end
  endtask

  task automatic test_stall();
    lat_fixed = 0; bus.id_ready = 1'b0;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        checks++;
        if (bus.id_valid !== 1'b1 || bus.instr !== memw(32'h0) || bus.pc_plus4 !== 32'h4) begin
          errors++; $display("FAIL stall_hold c%0d: got valid=%b instr=%h pc4=%h", c, bus.id_valid, bus.instr, bus.pc_plus4);
        end
      end
      if (c >= 3 && c <= 5) begin
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req c%0d: got %b want 0", c, bus.imem_req); end
      end
      if (c == 5) bus.id_ready = 1'b1;
      if (c == 6) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.id_valid !== 1'b0) begin
          errors++; $display("FAIL stall_resume: got req=%b addr=%h valid=%b want 1/4/0", bus.imem_req, bus.imem_addr, bus.id_valid);
        end
      end
      if (c == 7) begin
        checks++;
        if (bus.id_valid !== 1'b1 || bus.pc_plus4 !== 32'h8 || bus.instr !== memw(32'h4)) begin
          errors++; $display("FAIL stall_next: got valid=%b pc4=%h instr=%h", bus.id_valid, bus.pc_plus4, bus.instr);
        end
      end
    end
  endtask

  task automatic test_redirect_kill();
    bit seen;
    lat_fixed = 1; bus.id_ready = 1'b1;
    do_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.imem_ack !== 1'b0) begin
      errors++; $display("FAIL rk_setup: got req=%b addr=%h ack=%b want 1/8/0", bus.imem_req, bus.imem_addr, bus.imem_ack);
    end
    bus.redirect = 1'b1; bus.redirect_target = 32'h40;
    @(negedge clk);
    bus.redirect = 1'b0;
    checks++;
    if (bus.imem_addr !== 32'h40 || bus.id_valid !== 1'b0) begin
      errors++; $display("FAIL rk_target: got addr=%h valid=%b want 40/0", bus.imem_addr, bus.id_valid);
    end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.id_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (bus.instr !== memw(32'h40) || bus.pc_plus4 !== 32'h44) begin
          errors++; $display("FAIL rk_word: got instr=%h pc4=%h want %h/44", bus.instr, bus.pc_plus4, memw(32'h40));
        end
      end
    end
    if (!seen) begin errors++; checks++; $display("FAIL rk_timeout: got no valid want valid within 10 cycles"); end
  endtask

  task automatic test_redirect_ack();
    lat_fixed = 0; bus.id_ready = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.id_valid !== 1'b1 || bus.imem_ack !== 1'b1 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL ra_setup: got valid=%b ack=%b req=%b want 1/1/1", bus.id_valid, bus.imem_ack, bus.imem_req);
    end
    bus.redirect = 1'b1; bus.redirect_target = 32'h80;
    @(negedge clk);
    bus.redirect = 1'b0; bus.id_ready = 1'b1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h80 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL ra_flush: got valid=%b addr=%h req=%b want 0/80/1", bus.id_valid, bus.imem_addr, bus.imem_req);
    end
    @(negedge clk);
    checks++;
    if (bus.id_valid !== 1'b1 || bus.instr !== memw(32'h80) || bus.pc_plus4 !== 32'h84) begin
      errors++; $display("FAIL ra_next: got valid=%b instr=%h pc4=%h want 1/%h/84", bus.id_valid, bus.instr, bus.pc_plus4, memw(32'h80));
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    lat_fixed = 3; bus.id_ready = 1'b1;
    do_reset();
    bus.redirect = 1'b1; bus.redirect_target = 32'h10;
    @(negedge clk);
    bus.redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
      errors++; $display("FAIL rm_setup: got req=%b addr=%h want 1/10", bus.imem_req, bus.imem_addr);
    end
    reset = 1'b0; ack_force = 1'b1; lat_fixed = 0;
    @(negedge clk);
    reset = 1'b1; ack_force = 1'b0;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.instr !== 32'h0) begin
      errors++; $display("FAIL rm_state: got valid=%b req=%b addr=%h instr=%h want 0/0/0/0", bus.id_valid, bus.imem_req, bus.imem_addr, bus.instr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.id_valid !== 1'b1 || bus.pc_plus4 !== 32'h4 || bus.instr !== memw(32'h0)) begin
      errors++; $display("FAIL rm_refetch: got valid=%b pc4=%h instr=%h want 1/4/%h", bus.id_valid, bus.pc_plus4, bus.instr, memw(32'h0));
    end
    // Wrap: unaligned target low bits are ignored, and PC+4 wraps to zero.
    do_reset();
    bus.redirect = 1'b1; bus.redirect_target = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.redirect = 1'b0;
    checks++;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h want fffffffc", bus.imem_addr); end
    @(negedge clk);
    checks++;
    if (bus.imem_addr !== 32'h0 || bus.id_valid !== 1'b1 || bus.pc_plus4 !== 32'h0 || bus.instr !== memw(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_next: got addr=%h valid=%b pc4=%h instr=%h want 0/1/0/%h", bus.imem_addr, bus.id_valid, bus.pc_plus4, bus.instr, memw(32'hFFFF_FFFC));
    end
  endtask

  // Decode must see the program-order stream: each word is the one at the next sequential PC,
  // or at the redirect target after a redirect, regardless of latency, stalls or flushes.
  task automatic test_random();
    logic [31:0] exp_pc, exp_w, p_addr, tgt;
    logic        p_req, p_ack, p_redir, redir;
    int          delivered;
    exp_pc = 32'h0; delivered = 0;
    p_req = 1'b0; p_ack = 1'b0; p_redir = 1'b0; p_addr = 32'h0;
    lat_fixed = -1; bus.id_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (p_req && !p_ack && !p_redir) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== p_addr) begin
          errors++; $display("FAIL rnd_hold i%0d: got req=%b addr=%h want 1/%h", i, bus.imem_req, bus.imem_addr, p_addr);
        end
      end
      if (bus.id_valid !== 1'b1) begin
        checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL rnd_nop i%0d: got %h want 0", i, bus.instr); end
      end
      bus.id_ready = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      bus.redirect = redir; bus.redirect_target = tgt;
      if (bus.id_valid === 1'b1 && bus.id_ready) begin
        exp_w = memw(exp_pc);
        checks++;
        if (bus.pc_plus4 !== exp_pc + 32'd4 || bus.instr !== exp_w || bus.op !== exp_w[31:26]) begin
          errors++; $display("FAIL rnd_word i%0d: got pc4=%h instr=%h op=%h want %h/%h/%h", i, bus.pc_plus4, bus.instr, bus.op, exp_pc + 32'd4, exp_w, exp_w[31:26]);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redir) exp_pc = {tgt[31:2], 2'b00};
      p_req = bus.imem_req; p_ack = bus.imem_ack; p_addr = bus.imem_addr; p_redir = redir;
    end
    bus.redirect = 1'b0;
    checks++;
    if (delivered < 200) begin errors++; $display("FAIL rnd_progress: got %0d delivered want >= 200", delivered); end
  endtask

  initial begin
    bus.redirect = 1'b0;
    bus.redirect_target = 32'h0;
    bus.id_ready = 1'b1;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_kill();
    test_redirect_ack();
    test_reset_mid_and_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
